// File: rtl/alu_arbiter_pkg.sv
// rtl/alu_arbiter_pkg.sv - ISA types shared by the ALU arbiter: opcodes, ALU packet, arbiter states
package alu_arbiter_pkg;

    localparam int REGISTER_SIZE = 8;
    localparam int SPI_NSS_BITS  = 4;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4
    } Operation;

    // Field order puts op_code in the LSBs, so bit 0 on the wire is op_code[0].
    typedef struct packed {
        logic [REGISTER_SIZE-1:0] op_2;
        logic [REGISTER_SIZE-1:0] op_1;
        Operation                 op_code;
    } AluPacket;

    localparam int ALU_PACKET_WIDTH = $bits(AluPacket);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        TX    = 3'd2,
        WAIT  = 3'd3,
        RX    = 3'd4,
        DONE  = 3'd5
    } arb_state_t;

endpackage

// File: rtl/Spi.sv
// rtl/Spi.sv - SPI bus between the ALU arbiter (master) and the serial ALU slave
interface Spi;
    import alu_arbiter_pkg::*;

    logic [SPI_NSS_BITS-1:0] nss;
    logic                    mosi;
    logic                    miso;

    modport MasterSpi (output nss, output mosi, input miso);
    modport SlaveSpi  (input nss, input mosi, output miso);
endinterface

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin select: first set request at or after the pointer
module rr_picker #(
    parameter int  N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic          o_valid,
    output logic [IW-1:0] o_index
);
    logic [IW:0] w_cand;

    // Scan from the farthest offset down so the nearest requester is the last write.
    always_comb begin
        o_valid = 1'b0;
        o_index = '0;
        w_cand  = '0;
        for (int off = N - 1; off >= 0; off--) begin
            w_cand = {1'b0, i_ptr} + (IW + 1)'(off);
            if (w_cand >= (IW + 1)'(N)) begin
                w_cand = w_cand - (IW + 1)'(N);
            end
            if (i_req[w_cand[IW-1:0]]) begin
                o_valid = 1'b1;
                o_index = w_cand[IW-1:0];
            end
        end
    end
endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin SPI master sharing the serial ALU slave; ALU_ARBITER_TIMEOUT_EN adds a WAIT watchdog and o_error
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int NumRequesters = 4,
    parameter int NssPosition   = 0,
    parameter int TimeoutCycles = 64
) (
    input  logic                                         i_clock,
    input  logic                                         i_reset,
    input  logic [NumRequesters-1:0]                     i_req,
    input  Operation [NumRequesters-1:0]                 i_op_code,
    input  logic [NumRequesters-1:0][REGISTER_SIZE-1:0]  i_op_1,
    input  logic [NumRequesters-1:0][REGISTER_SIZE-1:0]  i_op_2,
    output logic [NumRequesters-1:0]                     o_grant,
    output logic [NumRequesters-1:0]                     o_done,
    output logic [REGISTER_SIZE-1:0]                     o_result,
    output logic                                         o_busy,
`ifdef ALU_ARBITER_TIMEOUT_EN
    output logic                                         o_error,
`endif
    Spi.MasterSpi                                        spi
);
    localparam int W  = ALU_PACKET_WIDTH;
    localparam int R  = REGISTER_SIZE;
    localparam int IW = $clog2(NumRequesters);
    localparam int TW = $clog2(W);
    localparam int RW = $clog2(R);

    arb_state_t               r_state;
    arb_state_t               w_next;
    logic [IW-1:0]            r_idx;
    logic [IW-1:0]            r_ptr;
    logic [IW-1:0]            w_pick_idx;
    logic                     w_pick_valid;
    AluPacket                 r_packet;
    logic [TW-1:0]            r_tx_cnt;
    logic [RW-1:0]            r_rx_cnt;
    logic [R-2:0]             r_rx_data;
    logic [R-1:0]             r_result;
    logic [NumRequesters-1:0] w_onehot;

`ifdef ALU_ARBITER_TIMEOUT_EN
    localparam int TOW = $clog2(TimeoutCycles + 1);
    logic [TOW-1:0] r_wait_cnt;
    logic           r_error;
    logic           w_timeout;
    assign w_timeout = !spi.miso && (r_wait_cnt == TOW'(TimeoutCycles - 1));
    assign o_error   = r_error;
`endif

    rr_picker #(.N(NumRequesters)) u_picker (
        .i_req   (i_req),
        .i_ptr   (r_ptr),
        .o_valid (w_pick_valid),
        .o_index (w_pick_idx)
    );

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:  if (w_pick_valid) w_next = START;
            START: w_next = TX;
            TX:    if (r_tx_cnt == TW'(W - 1)) w_next = WAIT;
            WAIT: begin
                if (spi.miso) begin
                    w_next = RX;
                end
`ifdef ALU_ARBITER_TIMEOUT_EN
                else if (w_timeout) begin
                    w_next = DONE;
                end
`endif
            end
            RX:    if (r_rx_cnt == RW'(R - 1)) w_next = DONE;
            DONE:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_idx     <= '0;
            r_ptr     <= '0;
            r_packet  <= '0;
            r_tx_cnt  <= '0;
            r_rx_cnt  <= '0;
            r_rx_data <= '0;
            r_result  <= '0;
`ifdef ALU_ARBITER_TIMEOUT_EN
            r_wait_cnt <= '0;
            r_error    <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    r_tx_cnt <= '0;
                    r_rx_cnt <= '0;
`ifdef ALU_ARBITER_TIMEOUT_EN
                    r_wait_cnt <= '0;
`endif
                    if (w_pick_valid) begin
                        r_idx            <= w_pick_idx;
                        r_packet.op_2    <= i_op_2[w_pick_idx];
                        r_packet.op_1    <= i_op_1[w_pick_idx];
                        r_packet.op_code <= i_op_code[w_pick_idx];
                    end
                end
                TX: begin
                    if (r_tx_cnt != TW'(W - 1)) r_tx_cnt <= r_tx_cnt + 1'b1;
                end
`ifdef ALU_ARBITER_TIMEOUT_EN
                WAIT: begin
                    r_wait_cnt <= r_wait_cnt + 1'b1;
                    if (w_timeout) begin
                        r_result <= '0;
                        r_error  <= 1'b1;
                    end
                end
`endif
                RX: begin
                    // Shift in from the top so the first (LSB) bit ends up at bit 0.
                    r_rx_data <= {spi.miso, r_rx_data[R-2:1]};
                    if (r_rx_cnt == RW'(R - 1)) begin
                        r_result <= {spi.miso, r_rx_data};
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                DONE: begin
                    r_ptr <= (r_idx == IW'(NumRequesters - 1)) ? '0 : r_idx + 1'b1;
`ifdef ALU_ARBITER_TIMEOUT_EN
                    r_error <= 1'b0;
`endif
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_onehot = NumRequesters'(1) << r_idx;
        o_grant  = (r_state != IDLE) ? w_onehot : '0;
        o_done   = (r_state == DONE) ? w_onehot : '0;
        o_busy   = (r_state != IDLE);
        spi.nss  = '1;
        spi.mosi = 1'b0;
        case (r_state)
            START: begin
                spi.nss[NssPosition] = 1'b0;
                spi.mosi             = 1'b1;
            end
            TX: begin
                spi.nss[NssPosition] = 1'b0;
                spi.mosi             = r_packet[r_tx_cnt];
            end
            WAIT, RX: spi.nss[NssPosition] = 1'b0;
            default: ;
        endcase
    end

    assign o_result = r_result;
endmodule
